// File: rtl/alu_result_stage.sv
// Purpose : buffers ALU results in a DEPTH-entry FIFO and tags each one with zero/negative/even-parity flags.
// Latency : a result pushed at edge t is presented at R/Z/N/P from cycle t+1; there is no combinational in->out path.
// Backpress: in_ready = not full, independent of out_ready; outputs hold stable while out_valid & ~out_ready.
//
// Ports:
//   clk, rst_n           - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    - producer handshake carrying Y_in
//   Y_in                 - ALU result to capture
//   out_valid/out_ready  - consumer handshake carrying R/Z/N/P
//   R, Z, N, P           - head result and its stored flags (zero when empty)
//   count                - entries currently held
//   result_cnt           - results delivered, modulo 2^16
module alu_result_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             Y_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             R,
    output logic                         Z,
    output logic                         N,
    output logic                         P,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [15:0]                  result_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             z;
        logic             n;
        logic             p;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_result_cnt;

    logic              w_push;
    logic              w_pop;
    entry_t            w_wr_entry;
    entry_t            w_head;

    // Handshake qualifiers come only from registered occupancy, so a pop
    // in the same cycle never frees a slot for a push while full.
    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Flags are fixed at capture time and travel with the entry.
    assign w_wr_entry.dat = Y_in;
    assign w_wr_entry.z   = (Y_in == '0);
    assign w_wr_entry.n   = Y_in[WIDTH-1];
    assign w_wr_entry.p   = ~^Y_in;

    // Storage needs no reset: the output is masked whenever nothing is held.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_result_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + PW'(1);
                r_result_cnt <= r_result_cnt + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Mask the head so an empty stage never shows stale data.
    always_comb begin
        w_head = '0;
        if (out_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign R          = w_head.dat;
    assign Z          = w_head.z;
    assign N          = w_head.n;
    assign P          = w_head.p;
    assign count      = r_count;
    assign result_cnt = r_result_cnt;

endmodule
